bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq.sv | 108 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Also produces a leading-zero blanking mask for the 7-segment display stage.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RESET = ~DIGITS'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_shift;
  logic [SW-1:0]     r_scratch;
  logic [CW-1:0]     r_count;

  logic [SW-1:0]       w_adjusted;
  logic [SW+WIDTH-1:0] w_combined;
  logic [SW-1:0]       w_nextScratch;
  logic [WIDTH-1:0]    w_nextShift;
  logic [DIGITS-1:0]   w_allZero;
  logic [DIGITS-1:0]   w_blank;
  logic                w_lastIter;

  // Add-3 correction per digit; carries never cross digit boundaries.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      assign w_adjusted[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ?
                                    (r_scratch[4*g +: 4] + 4'd3) :
                                    r_scratch[4*g +: 4];
    end
  endgenerate

  assign w_combined    = {w_adjusted, r_shift} << 1;
  assign w_nextScratch = w_combined[SW+WIDTH-1 -: SW];
  assign w_nextShift   = w_combined[WIDTH-1:0];
  assign w_lastIter    = (r_count == CW'(1));

  // A digit is blankable when it and every digit above it are zero.
  always_comb begin
    w_allZero = '0;
    w_allZero[DIGITS-1] = (w_nextScratch[4*(DIGITS-1) +: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      w_allZero[i] = w_allZero[i+1] && (w_nextScratch[4*i +: 4] == 4'd0);
    end
    w_blank    = w_allZero;
    w_blank[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      bcd_out   <= '0;
      blank     <= BLANK_RESET;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift   <= bin_in;
            r_scratch <= '0;
            r_count   <= CW'(WIDTH);
            busy      <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_scratch <= w_nextScratch;
          r_shift   <= w_nextShift;
          r_count   <= r_count - CW'(1);
          // The final iteration publishes the result straight from the shifter.
          if (w_lastIter) begin
            bcd_out <= w_nextScratch;
            blank   <= w_blank;
            done    <= 1'b1;
            valid   <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected digits,
// a monitor pops and compares on every done pulse.
module tb_bin_to_bcd_seq;

  typedef struct packed {
    logic [19:0] bcd;
    logic [4:0]  blank;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic        valid;
  logic [19:0] bcd_out;
  logic [4:0]  blank;

  int   checks;
  int   errors;
  int   doneCount;
  int   pushCount;
  exp_t expQ[$];

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bin_in(bin_in),
    .busy(busy),
    .done(done),
    .valid(valid),
    .bcd_out(bcd_out),
    .blank(blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      doneCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("bcd_out", 32'(bcd_out), 32'(e.bcd));
        checkOutput("blank", 32'(blank), 32'(e.blank));
        checkOutput("valid_at_done", 32'(valid), 32'd1);
        checkOutput("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Drives a one-cycle start; the value is accepted at the following posedge.
  task automatic applyStimulus(input logic [15:0] value, input logic [19:0] expBcd,
                               input logic [4:0] expBlank, input bit expectResult);
    @(negedge clk);
    bin_in = value;
    start  = 1'b1;
    if (expectResult) begin
      expQ.push_back('{bcd: expBcd, blank: expBlank});
      pushCount++;
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Called on the negedge right after the accepting edge; returns cycles to done.
  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_valid"}, 32'(valid), 32'd0);
    checkOutput({tag, "_bcd"}, 32'(bcd_out), 32'h0);
    checkOutput({tag, "_blank"}, 32'(blank), 32'b11110);
  endtask

  initial begin
    int lat;
    checks = 0; errors = 0; doneCount = 0; pushCount = 0;
    reset = 1'b1; start = 1'b0; bin_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkResetState("reset");

    applyStimulus(16'd12345, 20'h12345, 5'b00000, 1'b1);
    waitDone(lat);
    checkOutput("latency_12345", 32'(lat), 32'd16);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("valid_held", 32'(valid), 32'd1);
    checkOutput("bcd_stable", 32'(bcd_out), 32'h12345);

    applyStimulus(16'd65535, 20'h65535, 5'b00000, 1'b1);
    waitDone(lat);
    applyStimulus(16'd0, 20'h00000, 5'b11110, 1'b1);
    waitDone(lat);
    applyStimulus(16'd907, 20'h00907, 5'b11000, 1'b1);
    waitDone(lat);

    // Start during busy and bin_in churn are ignored; start held into done restarts.
    applyStimulus(16'd42, 20'h00042, 5'b11100, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; bin_in = 16'd999;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; bin_in = 16'd7;
    expQ.push_back('{bcd: 20'h00007, blank: 5'b11110});
    pushCount++;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) checkOutput("done_timeout_42", 32'd0, 32'd1);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_done_low", 32'(done), 32'd0);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    checkOutput("b2b_bcd_stable", 32'(bcd_out), 32'h00042);
    waitDone(lat);
    checkOutput("latency_b2b", 32'(lat), 32'd16);

    // Reset mid-conversion aborts without a done pulse.
    applyStimulus(16'd500, 20'h0, 5'b0, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkResetState("abort");
    repeat (20) @(negedge clk);
    checkResetState("abort_idle");

    // Reset and start together: reset wins.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; bin_in = 16'd123;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_start_busy", 32'(busy), 32'd0);

    applyStimulus(16'd500, 20'h00500, 5'b11000, 1'b1);
    waitDone(lat);
    checkOutput("latency_500", 32'(lat), 32'd16);
    repeat (3) @(negedge clk);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    checkOutput("done_count", 32'(doneCount), 32'(pushCount));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
